store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Posted-write buffer between the CPU store path and the data RAM write port (WriteMem / MemWriteIndex / DataIn).
- Accepts stores in one cycle and drains them to RAM in FIFO order, one per clock.
- Forwards buffered data to loads so a load that follows a store reads the correct value.
- Lets the datapath retire a store without waiting on the RAM write.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 16, word address width.
- DEPTH, 4, number of buffer entries; must be a power of 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous active-high reset.
- StoreValid  in  1  store request this cycle.
- StoreAddr  in  ADDR_W  store word address.
- StoreData  in  DATA_W  store data.
- StoreReady  out  1  buffer can accept a store; equals count<DEPTH.
- LoadAddr  in  ADDR_W  address of the current load, for forwarding.
- LoadHit  out  1  a valid entry matches LoadAddr.
- LoadData  out  DATA_W  forwarded data; 0 when LoadHit=0.
- DrainHold  in  1  suppresses draining this cycle.
- RamWriteMem  out  1  write strobe to RAM.
- RamWriteIndex  out  ADDR_W  head entry address.
- RamDataIn  out  DATA_W  head entry data.
- Count  out  PTR_W+1  number of occupied entries.
- Empty  out  1  Count==0.

Behaviour:
- Storage: circular array of {addr, data, valid}, with head pointer, tail pointer and count registers. All outputs are driven from registers, or are combinational only on registers plus LoadAddr.
- Reset: at a posedge with RST=1:
  - pointers = 0, count = 0, all valid bits = 0.
  - Resulting outputs: StoreReady=1, Empty=1, Count=0, RamWriteMem=0, LoadHit=0, LoadData=0.
  - Entries present when reset hits mid-operation are discarded, never written to RAM.
  - RST has priority over push and pop.
- Push: at a posedge with StoreValid && StoreReady:
  - write {StoreAddr, StoreData} to tail, set its valid bit, tail+1 mod DEPTH.
  - StoreValid while StoreReady=0 is ignored; the requester holds the request.
  - A push is not accepted when full, even if a pop happens in the same cycle. This avoids a combinational path from DrainHold to StoreReady.
- Drain:
  - RamWriteMem = !Empty && !DrainHold, combinational.
  - RamWriteIndex and RamDataIn = head entry.
  - At the posedge where RamWriteMem=1, the RAM commits the write and the buffer pops: clear head valid, head+1 mod DEPTH.
- Latency:
  - A store accepted at edge N appears on the RAM outputs after edge N when the buffer was empty.
  - Earliest RAM commit is edge N+1.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Forwarding:
  - LoadHit and LoadData are combinational against all valid entries.
  - When several entries match, the youngest (closest to tail) wins.
  - A store being presented in the same cycle is not forwarded. The CPU must not issue a load and a store in the same cycle.
  - The head entry being popped this cycle still forwards, because the RAM has not yet written it.
- Address compare uses full ADDR_W bits; no truncation.
- Pointer wrap: DEPTH-1 -> 0. Count ranges 0..DEPTH.

Optional Feature:
- STORE_MERGE_EN defined:
  - An accepted store whose address matches the youngest valid entry overwrites that entry's data in place; no new entry is allocated and tail/count are unchanged.
  - Exception: if that entry is the head and is popping this cycle, the store is pushed normally.
  - StoreReady rule is unchanged.
- STORE_MERGE_EN undefined: every accepted store allocates a new entry.

Decomposition:
- Package sb_pkg holds:
  - DATA_W, ADDR_W, DEPTH and PTR_W constants.
  - sb_entry_t typedef {valid, addr, data}.
  - sb_ptr_t typedef.
- Sub-module sb_fwd_match: pure combinational youngest-first priority match. Inputs are the entries array, head, count and LoadAddr; outputs are hit and data.

Test Plan:
- Reset then idle -> StoreReady=1, Empty=1, Count=0, RamWriteMem=0, LoadHit=0, LoadData=0.
- Store 0x0010<-0xBEEF with DrainHold=0 -> next cycle RamWriteMem=1, RamWriteIndex=0x0010, RamDataIn=0xBEEF; one cycle later Empty=1.
- DrainHold=1; stores to 0x01,0x02,0x03,0x04 -> Count=4, StoreReady=0. A fifth store is ignored. Release DrainHold -> RAM writes occur in order 0x01..0x04 on 4 consecutive edges.
- DrainHold=1; store 0x20<-0x1111 then 0x20<-0x2222; LoadAddr=0x20 -> LoadHit=1, LoadData=0x2222. Count=2, or Count=1 with STORE_MERGE_EN.
- Count=3 with DrainHold=0, store accepted same cycle -> Count stays 3, pointers advance with wrap 3->0.
- Count=3, assert RST for one edge -> Count=0, Empty=1, RamWriteMem=0, no further RAM writes.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared constants and types for the store buffer: geometry, pointer type and
// the per-entry record used by the buffer array and the forwarding matcher.
package sb_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 4;
    localparam int PTR_W  = 2;

    // Occupancy value meaning "every slot holds a store".
    localparam logic [PTR_W:0] SB_FULL = (PTR_W + 1)'(DEPTH);

    typedef logic [PTR_W-1:0] sb_ptr_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Load-forwarding matcher: scans occupied entries oldest to youngest so the
// youngest matching store supplies the data; data reads 0 on a miss.
module sb_fwd_match
    import sb_pkg::*;
(
    input  sb_entry_t [DEPTH-1:0] entries,
    input  sb_ptr_t               head,
    input  logic [PTR_W:0]        count,
    input  logic [ADDR_W-1:0]     load_addr,
    output logic                  hit,
    output logic [DATA_W-1:0]     data
);

    sb_ptr_t idx;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = head;
        // Later iterations are younger, so the last match overrides earlier ones.
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (((PTR_W + 1)'(k) < count) && entries[idx].valid &&
                (entries[idx].addr == load_addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: FIFO of stores drained to the RAM write port with
// youngest-first load forwarding. Optional in-place merging via STORE_MERGE_EN.
module store_buffer
    import sb_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              StoreValid,
    input  logic [ADDR_W-1:0] StoreAddr,
    input  logic [DATA_W-1:0] StoreData,
    output logic              StoreReady,
    input  logic [ADDR_W-1:0] LoadAddr,
    output logic              LoadHit,
    output logic [DATA_W-1:0] LoadData,
    input  logic              DrainHold,
    output logic              RamWriteMem,
    output logic [ADDR_W-1:0] RamWriteIndex,
    output logic [DATA_W-1:0] RamDataIn,
    output logic [PTR_W:0]    Count,
    output logic              Empty
);

    sb_entry_t [DEPTH-1:0] entries;
    sb_ptr_t               head;
    sb_ptr_t               tail;
    logic [PTR_W:0]        count;

    logic push;
    logic pop;
    logic alloc;
    logic merge;

    // Handshake: a store transfers on any edge where StoreValid && StoreReady;
    // StoreReady depends only on registered occupancy, never on DrainHold, so a
    // full buffer refuses stores even in a cycle where it also drains.
    assign StoreReady = (count != SB_FULL);
    assign Empty      = (count == '0);
    assign Count      = count;

    assign push        = StoreValid && StoreReady;
    assign pop         = !Empty && !DrainHold;
    assign RamWriteMem = pop;

    assign RamWriteIndex = entries[head].addr;
    assign RamDataIn     = entries[head].data;

`ifdef STORE_MERGE_EN
    sb_ptr_t youngest;
    logic    youngest_popping;

    assign youngest         = tail - PTR_W'(1);
    // A youngest entry that is also leaving this edge cannot absorb the store.
    assign youngest_popping = pop && (youngest == head);
    assign merge = push && !Empty && entries[youngest].valid &&
                   (entries[youngest].addr == StoreAddr) && !youngest_popping;
`else
    assign merge = 1'b0;
`endif

    assign alloc = push && !merge;

    always_ff @(posedge CLK) begin
        if (RST) begin
            entries <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            if (pop) begin
                entries[head].valid <= 1'b0;
                head                <= head + PTR_W'(1);
            end
            if (alloc) begin
                entries[tail] <= {1'b1, StoreAddr, StoreData};
                tail          <= tail + PTR_W'(1);
            end
`ifdef STORE_MERGE_EN
            if (merge) begin
                entries[youngest].data <= StoreData;
            end
`endif
            case ({alloc, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    sb_fwd_match u_fwd (
        .entries   (entries),
        .head      (head),
        .count     (count),
        .load_addr (LoadAddr),
        .hit       (LoadHit),
        .data      (LoadData)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a RAM-side monitor checks every committed
// write against an expected queue; status and forwarding are checked inline.
module tb_store_buffer;
    import sb_pkg::*;

    logic              CLK;
    logic              RST;
    logic              StoreValid;
    logic [ADDR_W-1:0] StoreAddr;
    logic [DATA_W-1:0] StoreData;
    logic              StoreReady;
    logic [ADDR_W-1:0] LoadAddr;
    logic              LoadHit;
    logic [DATA_W-1:0] LoadData;
    logic              DrainHold;
    logic              RamWriteMem;
    logic [ADDR_W-1:0] RamWriteIndex;
    logic [DATA_W-1:0] RamDataIn;
    logic [PTR_W:0]    Count;
    logic              Empty;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    store_buffer dut (
        .CLK           (CLK),
        .RST           (RST),
        .StoreValid    (StoreValid),
        .StoreAddr     (StoreAddr),
        .StoreData     (StoreData),
        .StoreReady    (StoreReady),
        .LoadAddr      (LoadAddr),
        .LoadHit       (LoadHit),
        .LoadData      (LoadData),
        .DrainHold     (DrainHold),
        .RamWriteMem   (RamWriteMem),
        .RamWriteIndex (RamWriteIndex),
        .RamDataIn     (RamDataIn),
        .Count         (Count),
        .Empty         (Empty)
    );

    // Clock / watchdog
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input bit accept);
        StoreValid = 1'b1;
        StoreAddr  = a;
        StoreData  = d;
        if (accept) exp_q.push_back({a, d});
        step();
        StoreValid = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every RAM commit must match the oldest expected store
    always @(negedge CLK) begin
        if (!RST && RamWriteMem) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ram_write_unexpected: actual=0x%0h<-0x%0h required=none",
                         RamWriteIndex, RamDataIn);
            end else begin
                logic [ADDR_W+DATA_W-1:0] exp;
                exp = exp_q.pop_front();
                if ({RamWriteIndex, RamDataIn} !== exp) begin
                    errors++;
                    $display("FAIL ram_write: actual=0x%0h<-0x%0h required=0x%0h<-0x%0h",
                             RamWriteIndex, RamDataIn, exp[ADDR_W+DATA_W-1:DATA_W],
                             exp[DATA_W-1:0]);
                end
            end
        end
    end

    initial begin
        RST        = 1'b1;
        StoreValid = 1'b0;
        StoreAddr  = '0;
        StoreData  = '0;
        LoadAddr   = '0;
        DrainHold  = 1'b0;
        step();
        step();
        RST = 1'b0;

        // Reset state
        @(negedge CLK);
        check("rst_store_ready", 32'(StoreReady), 32'd1);
        check("rst_empty", 32'(Empty), 32'd1);
        check("rst_count", 32'(Count), 32'd0);
        check("rst_ram_write", 32'(RamWriteMem), 32'd0);
        check("rst_load_hit", 32'(LoadHit), 32'd0);
        check("rst_load_data", 32'(LoadData), 32'd0);

        // Single store drains on the next cycle
        step();
        store(16'h0010, 16'hBEEF, 1'b1);
        @(negedge CLK);
        check("single_ram_write", 32'(RamWriteMem), 32'd1);
        check("single_count", 32'(Count), 32'd1);
        step();
        @(negedge CLK);
        check("single_empty_after", 32'(Empty), 32'd1);

        // Fill under DrainHold, refuse the fifth, then drain in order
        step();
        DrainHold = 1'b1;
        store(16'h0001, 16'hA001, 1'b1);
        store(16'h0002, 16'hA002, 1'b1);
        store(16'h0003, 16'hA003, 1'b1);
        store(16'h0004, 16'hA004, 1'b1);
        @(negedge CLK);
        check("full_count", 32'(Count), 32'd4);
        check("full_store_ready", 32'(StoreReady), 32'd0);
        check("full_ram_write_held", 32'(RamWriteMem), 32'd0);
        step();
        store(16'h0005, 16'hA005, 1'b0);
        LoadAddr = 16'h0003;
        @(negedge CLK);
        check("full_count_after_fifth", 32'(Count), 32'd4);
        check("fwd_hit_0003", 32'(LoadHit), 32'd1);
        check("fwd_data_0003", 32'(LoadData), 32'h0000A003);
        step();
        LoadAddr = 16'h0103;
        @(negedge CLK);
        check("fwd_full_addr_miss", 32'(LoadHit), 32'd0);
        check("fwd_miss_data_zero", 32'(LoadData), 32'd0);
        step();
        DrainHold = 1'b0;
        step();
        step();
        step();
        step();
        @(negedge CLK);
        check("drain4_empty", 32'(Empty), 32'd1);

        // Same address twice: youngest forwards
        step();
        DrainHold = 1'b1;
`ifdef STORE_MERGE_EN
        store(16'h0020, 16'h1111, 1'b0);
`else
        store(16'h0020, 16'h1111, 1'b1);
`endif
        store(16'h0020, 16'h2222, 1'b1);
        LoadAddr = 16'h0020;
        @(negedge CLK);
        check("dup_fwd_hit", 32'(LoadHit), 32'd1);
        check("dup_fwd_data", 32'(LoadData), 32'h00002222);
`ifdef STORE_MERGE_EN
        check("dup_count", 32'(Count), 32'd1);
`else
        check("dup_count", 32'(Count), 32'd2);
`endif
        step();
        DrainHold = 1'b0;
        step();
        step();
        @(negedge CLK);
        check("dup_drained_empty", 32'(Empty), 32'd1);
        check("dup_drained_no_hit", 32'(LoadHit), 32'd0);

        // Push and pop in the same cycle at Count=3
        step();
        DrainHold = 1'b1;
        store(16'h0030, 16'hC030, 1'b1);
        store(16'h0031, 16'hC031, 1'b1);
        store(16'h0032, 16'hC032, 1'b1);
        @(negedge CLK);
        check("pp_count_before", 32'(Count), 32'd3);
        step();
        DrainHold = 1'b0;
        store(16'h0033, 16'hC033, 1'b1);
        DrainHold = 1'b1;
        LoadAddr  = 16'h0033;
        @(negedge CLK);
        check("pp_count_after", 32'(Count), 32'd3);
        check("pp_fwd_new_hit", 32'(LoadHit), 32'd1);
        check("pp_fwd_new_data", 32'(LoadData), 32'h0000C033);
        step();
        LoadAddr = 16'h0030;
        @(negedge CLK);
        check("pp_popped_no_hit", 32'(LoadHit), 32'd0);

        // Reset with three entries buffered: they are discarded
        step();
        RST = 1'b1;
        exp_q.delete();
        step();
        RST       = 1'b0;
        DrainHold = 1'b0;
        LoadAddr  = 16'h0033;
        @(negedge CLK);
        check("midrst_count", 32'(Count), 32'd0);
        check("midrst_empty", 32'(Empty), 32'd1);
        check("midrst_ram_write", 32'(RamWriteMem), 32'd0);
        check("midrst_store_ready", 32'(StoreReady), 32'd1);
        check("midrst_load_hit", 32'(LoadHit), 32'd0);
        for (int i = 0; i < 5; i++) step();

        // Buffer still works after reset
        store(16'h0040, 16'h5555, 1'b1);
        step();
        step();
        @(negedge CLK);
        check("post_rst_empty", 32'(Empty), 32'd1);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
